// File: rtl/seq_shifter_if.sv
// Request/response bundle for seq_shifter: the requester drives start and the
// operands, and the shifter drives busy, done and the registered result.
interface seq_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               start;
  logic [1:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_in;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   data_out;

  modport master (
    output start, op, shamt, data_in,
    input  busy, done, data_out
  );

  modport slave (
    input  start, op, shamt, data_in,
    output busy, done, data_out
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: shifts the latched operand by up to STEP bits per clock
// (SLL, SRL, SRA, ROTL), then pulses done for one cycle with the result.
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         reset,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;

  // The remaining count never exceeds WIDTH-1, so capping the per-clock step
  // at WIDTH-1 gives the same min() while keeping it in SHAMT_W bits.
  localparam int               STEP_CAP = (STEP >= WIDTH) ? (WIDTH - 1) : STEP;
  localparam logic [SHAMT_W-1:0] STEP_M = SHAMT_W'(STEP_CAP);

  // Single shift of w by k; fill is the sign of the originally latched operand.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [1:0]         op,
    input logic [WIDTH-1:0]   w,
    input logic [SHAMT_W-1:0] k,
    input logic               fill
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fill_mask;
    fill_mask = ~({WIDTH{1'b1}} >> k);
    case (op)
      OP_SLL:  r = w << k;
      OP_SRL:  r = w >> k;
      OP_SRA:  r = (w >> k) | (fill ? fill_mask : {WIDTH{1'b0}});
      // WIDTH - k computed modulo 2**SHAMT_W; k=0 degenerates to w|w = w.
      OP_ROTL: r = (w << k) | (w >> ({SHAMT_W{1'b0}} - k));
      default: r = w;
    endcase
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   wrk_q, wrk_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic [SHAMT_W-1:0] k_s;

  // Bits to shift this clock: min(STEP, remaining).
  always_comb begin
    if (rem_q < STEP_M) begin
      k_s = rem_q;
    end else begin
      k_s = STEP_M;
    end
  end

  // Next-state and next-output logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_d     = sign_q;
    wrk_d      = wrk_q;
    rem_d      = rem_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          sign_d = bus.data_in[WIDTH-1];
          wrk_d  = bus.data_in;
          rem_d  = bus.shamt;
          if (bus.shamt == {SHAMT_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        wrk_d = shift_by(op_q, wrk_q, k_s, sign_q);
        rem_d = rem_q - k_s;
        if (rem_q == k_s) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        data_out_d = wrk_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  // State and registered outputs; reset clears everything without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      sign_q     <= 1'b0;
      wrk_q      <= {WIDTH{1'b0}};
      rem_q      <= {SHAMT_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_q     <= sign_d;
      wrk_q      <= wrk_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: three instances (STEP 1, 4, 32) share stimulus and are
// checked against an arithmetic reference of result value and completion cycle.
module tb_seq_shifter;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus1 ();
  seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus4 ();
  seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus32 ();

  seq_shifter #(.WIDTH(32), .STEP(1),  .SHAMT_W(5)) dut1  (.clk(clk), .reset(reset), .bus(bus1));
  seq_shifter #(.WIDTH(32), .STEP(4),  .SHAMT_W(5)) dut4  (.clk(clk), .reset(reset), .bus(bus4));
  seq_shifter #(.WIDTH(32), .STEP(32), .SHAMT_W(5)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
    bus1.start  = st; bus1.op  = o; bus1.shamt  = s; bus1.data_in  = d;
    bus4.start  = st; bus4.op  = o; bus4.shamt  = s; bus4.data_in  = d;
    bus32.start = st; bus32.op = o; bus32.shamt = s; bus32.data_in = d;
  endtask

  task automatic drive_junk();
    drive(1'b0, 2'($urandom_range(3, 0)), 5'($urandom_range(31, 0)), $urandom);
  endtask

  // Reference result from the operation definitions.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
    logic signed [31:0] sd;
    logic [31:0] r;
    sd = d;
    case (o)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = sd >>> s;
      default: r = (s == 5'd0) ? d : ((d << s) | (d >> (6'd32 - {1'b0, s})));
    endcase
    return r;
  endfunction

  function automatic int steps(input int s, input int step);
    return (s + step - 1) / step;
  endfunction

  // n = index of the edge just before this sample; accept edge is n=0.
  task automatic chk_cycle(input string name, input int n, input int m, input logic busy,
                           input logic done, input logic [31:0] dout, input logic [31:0] exp);
    chk($sformatf("%s n%0d m%0d busy", name, n, m), {31'd0, busy}, {31'd0, (n <= m)});
    chk($sformatf("%s n%0d m%0d done", name, n, m), {31'd0, done}, {31'd0, (n == m + 1)});
    if (n == m + 1) chk($sformatf("%s n%0d m%0d data_out", name, n, m), dout, exp);
  endtask

  // One request on all three instances; called at a falling edge.
  task automatic run_req(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
    logic [31:0] exp;
    int m1, m4, m32;
    exp = model(o, s, d);
    m1  = steps(int'(s), 1);
    m4  = steps(int'(s), 4);
    m32 = steps(int'(s), 32);
    drive(1'b1, o, s, d);
    @(posedge clk);
    for (int n = 0; n <= 33; n++) begin
      @(negedge clk);
      chk_cycle($sformatf("s1 op%0d sh%0d", o, s),  n, m1,  bus1.busy,  bus1.done,  bus1.data_out,  exp);
      chk_cycle($sformatf("s4 op%0d sh%0d", o, s),  n, m4,  bus4.busy,  bus4.done,  bus4.data_out,  exp);
      chk_cycle($sformatf("s32 op%0d sh%0d", o, s), n, m32, bus32.busy, bus32.done, bus32.data_out, exp);
      // Junk operands, and random start only while that instance must ignore it.
      drive_junk();
      bus1.start  = (n <= m1)  ? 1'($urandom_range(1, 0)) : 1'b0;
      bus4.start  = (n <= m4)  ? 1'($urandom_range(1, 0)) : 1'b0;
      bus32.start = (n <= m32) ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    chk("s1 hold",  bus1.data_out,  exp);
    chk("s4 hold",  bus4.data_out,  exp);
    chk("s32 hold", bus32.data_out, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " s1 busy"},   {31'd0, bus1.busy},  32'd0);
    chk({tag, " s1 done"},   {31'd0, bus1.done},  32'd0);
    chk({tag, " s1 dout"},   bus1.data_out,       32'd0);
    chk({tag, " s4 busy"},   {31'd0, bus4.busy},  32'd0);
    chk({tag, " s4 done"},   {31'd0, bus4.done},  32'd0);
    chk({tag, " s4 dout"},   bus4.data_out,       32'd0);
    chk({tag, " s32 busy"},  {31'd0, bus32.busy}, 32'd0);
    chk({tag, " s32 done"},  {31'd0, bus32.done}, 32'd0);
    chk({tag, " s32 dout"},  bus32.data_out,      32'd0);
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed cases.
    run_req(2'b00, 5'd2,  32'h0000_0001);
    run_req(2'b10, 5'd4,  32'h8000_0000);
    run_req(2'b01, 5'd4,  32'h8000_0000);
    run_req(2'b01, 5'd31, 32'hF000_0000);
    run_req(2'b11, 5'd1,  32'h8000_0001);
    run_req(2'b00, 5'd0,  32'h1234_5678);
    run_req(2'b10, 5'd31, 32'h8000_0000);
    run_req(2'b11, 5'd31, 32'hDEAD_BEEF);
    run_req(2'b10, 5'd5,  32'h7FFF_FFFF);

    // Random cases.
    repeat (24) run_req(2'($urandom_range(3, 0)), 5'($urandom_range(31, 0)), $urandom);

    // Back-to-back: start held high, shamt=3 (m=3 for STEP 1, m=1 otherwise).
    d = $urandom;
    drive(1'b1, 2'b00, 5'd3, d);
    @(posedge clk);
    for (int n = 0; n <= 24; n++) begin
      @(negedge clk);
      chk($sformatf("b2b s1 n%0d busy", n), {31'd0, bus1.busy}, {31'd0, ((n % 5) <= 3)});
      chk($sformatf("b2b s1 n%0d done", n), {31'd0, bus1.done}, {31'd0, ((n % 5) == 4)});
      if ((n % 5) == 4) chk($sformatf("b2b s1 n%0d dout", n), bus1.data_out, d << 3);
      chk($sformatf("b2b s4 n%0d busy", n),  {31'd0, bus4.busy},  {31'd0, ((n % 3) <= 1)});
      chk($sformatf("b2b s4 n%0d done", n),  {31'd0, bus4.done},  {31'd0, ((n % 3) == 2)});
      chk($sformatf("b2b s32 n%0d busy", n), {31'd0, bus32.busy}, {31'd0, ((n % 3) <= 1)});
      chk($sformatf("b2b s32 n%0d done", n), {31'd0, bus32.done}, {31'd0, ((n % 3) == 2)});
      if (n == 24) drive(1'b0, 2'b00, 5'd0, 32'd0);
    end
    repeat (4) @(negedge clk);
    chk("b2b s1 idle",  {31'd0, bus1.busy}, 32'd0);
    chk("b2b s4 idle",  {31'd0, bus4.busy}, 32'd0);
    chk("b2b s4 dout",  bus4.data_out,      d << 3);
    chk("b2b s32 dout", bus32.data_out,     d << 3);

    // Reset in the middle of a shamt=20 request.
    d = $urandom;
    drive(1'b1, 2'b01, 5'd20, d);
    @(posedge clk);
    @(negedge clk);
    drive_junk();
    repeat (2) @(negedge clk);
    chk("abort s1 busy before", {31'd0, bus1.busy},  32'd1);
    chk("abort s4 busy before", {31'd0, bus4.busy},  32'd1);
    chk("abort s32 dout before", bus32.data_out,     d >> 20);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("abort");
    // start must be ignored while reset is high.
    drive(1'b1, 2'b00, 5'd7, $urandom);
    @(posedge clk);
    @(negedge clk);
    chk_zero("held");
    reset = 1'b0;
    run_req(2'b10, 5'd20, 32'h9000_00F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
